fir_order_scheduler: RTL and testbench
======================================

Name: fir_order_scheduler

Overview:
- Controller that collects up to 15 candidate costs for one block, such as the total bit counts for predictor orders 0..14 or for Rice-parameter candidates.
- Owns one 15-way pipelined minimum unit: 4 enabled stages, 31-bit unsigned, strict less-than.
- Sequences that unit and reports the winning candidate index and its cost to the encoder's frame-assembly logic.
- Sits between the parallel cost estimators (serialised requesters) and the subframe writer.

Parameters:
- COST_W, 31, width of each cost value; must match the minimum unit.
- NCAND, 15, number of candidate slots; fixed by the minimum unit.
- CMP_LAT, 4, enabled clock edges from the minimum unit's input to its result.

Ports:
- iClock  in  1  system clock.
- iReset  in  1  synchronous, active-high reset.
- iStart  in  1  begin a new block; clears all slots.
- iValid  in  1  candidate offered this cycle.
- iIndex  in  4  candidate slot 0..14.
- iCost  in  COST_W  candidate cost.
- oReady  out  1  candidates are accepted this cycle.
- iFinish  in  1  evaluate now, with missing slots treated as unreachable.
- oBusy  out  1  high in FLUSH and CAPTURE.
- oDone  out  1  one-cycle pulse; result valid.
- oBestIndex  out  4  winning slot.
- oBestCost  out  COST_W  cost of the winning slot.
- oEmpty  out  1  no candidate was received in the evaluated block; valid with oDone.
- oError  out  1  sticky; set by iIndex > 14 while iValid && oReady. Cleared by iStart or iReset.

Behaviour:
- Reset: applies on any iReset edge, including mid-FLUSH.
  - State goes to IDLE; minimum-unit enable goes low.
  - Slot registers are set to all-ones; the received-mask is cleared.
  - Outputs go to oReady=0, oBusy=0, oDone=0, oBestIndex=0, oBestCost=0, oEmpty=0, oError=0.
- State IDLE: oReady=0. iStart → COLLECT (clears mask and oError, sets slots to all-ones). Other inputs are ignored.
- State COLLECT: oReady=1.
  - Accept rule: iValid && iIndex<=14 writes slot[iIndex]=iCost and sets mask bit.
  - Duplicate index: the later write overwrites.
  - Bad index (>14): the value is dropped and oError is set.
  - Transition to FLUSH at the edge where either:
    - iFinish=1, or
    - the mask becomes all-ones (15th distinct slot).
  - If an accept coincides with iFinish, the candidate is stored first, then FLUSH is entered.
  - iStart in COLLECT restarts the block (clears slots and mask), taking priority over iValid and iFinish.
- State FLUSH: lasts exactly CMP_LAT cycles.
  - oReady=0 and oBusy=1.
  - Minimum-unit enable is 1; its inputs are the frozen slot registers.
  - A down-counter of 2 bits counts 3..0; on 0 → CAPTURE.
  - iStart, iValid and iFinish are ignored.
- State CAPTURE: lasts 1 cycle.
  - Registers oBestIndex = unit result and oBestCost = slot[result].
  - Registers oEmpty = (mask==0).
  - Enable=0. Next state DONE.
- State DONE: lasts 1 cycle.
  - oDone=1 and oBusy=0; → IDLE.
  - oBestIndex, oBestCost and oEmpty hold until the next CAPTURE or reset.
- Latency: oDone is high in the 6th cycle after the edge that sampled the triggering iFinish or 15th accept.
- Throughput: one block per (collect time + 6) cycles.
- Arithmetic: compare is unsigned. Missing slots hold 2^COST_W−1, so they lose to any received cost except an equal all-ones value.
- Ties: equal costs resolve to the highest tied index (inherited from the unit's strict-less-than tree).
- Empty block: all slots are all-ones, giving oBestIndex=14, oBestCost=all-ones, oEmpty=1.

Test Plan:
- Full-block auto-finish:
  - Stimulus: reset, iStart, then 15 accepts with cost[i]=1000−i·10, except cost[7]=5.
  - Response: oDone 6 cycles after the 15th accept; oBestIndex=7, oBestCost=5, oEmpty=0, oError=0.
- Partial block with iFinish:
  - Stimulus: accept slots 2 (cost 40), 9 (cost 30), 12 (cost 31); iFinish asserted alongside the slot-12 accept.
  - Response: oBestIndex=9, oBestCost=30; no further accepts while oReady=0.
- Tie and duplicate:
  - Stimulus: slot 3 gets cost 100, then slot 3 gets 50; slots 5 and 11 get 50; finish.
  - Response: oBestIndex=11, oBestCost=50.
- Empty and error:
  - Stimulus: iStart; iValid with iIndex=15; iFinish.
  - Response: oError=1 (sticky until next iStart), oEmpty=1, oBestIndex=14, oBestCost=0x7FFFFFFF.
- Reset mid-FLUSH:
  - Stimulus: assert iReset on the 2nd FLUSH cycle, then run a new block with slot 0 cost 1 and iFinish.
  - Response: no oDone for the aborted block; outputs are 0 after reset; new block yields oBestIndex=0, oBestCost=1.
- Restart in COLLECT:
  - Stimulus: accept slot 4 (cost 1), iStart, accept slot 6 (cost 9), iFinish.
  - Response: oBestIndex=6, oBestCost=9.

Source files
------------

// File: rtl/fir_order_scheduler.sv
// Candidate-cost collector and sequencer around a 15-way, 4-stage pipelined
// minimum unit; reports the winning slot index and its cost once per block.
module fir_order_scheduler #(
    parameter int COST_W  = 31,
    parameter int NCAND   = 15,
    parameter int CMP_LAT = 4
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iStart,
    input  logic              iValid,
    input  logic [3:0]        iIndex,
    input  logic [COST_W-1:0] iCost,
    output logic              oReady,
    input  logic              iFinish,
    output logic              oBusy,
    output logic              oDone,
    output logic [3:0]        oBestIndex,
    output logic [COST_W-1:0] oBestCost,
    output logic              oEmpty,
    output logic              oError
);

    localparam int CW = COST_W + 4;
    localparam logic [NCAND-1:0] MASK_FULL = {NCAND{1'b1}};
    localparam logic [NCAND-1:0] MASK_ONE  = {{(NCAND-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [COST_W-1:0] slot_r [0:NCAND-1];
    logic [NCAND-1:0]  mask_r;
    logic [NCAND-1:0]  mask_s;
    logic              err_r;
    logic [1:0]        cnt_r;
    logic              start_s;
    logic              accept_s;
    logic              bad_s;
    logic              en_s;
    logic              ready_s;
    logic              busy_s;
    logic              done_s;
    logic [CW-1:0]     cand_s [0:NCAND-1];
    logic [CW-1:0]     s1_r [0:7];
    logic [CW-1:0]     s2_r [0:3];
    logic [CW-1:0]     s3_r [0:1];
    logic [CW-1:0]     s4_r;

    // Entries are {cost, index}; ties go to the right operand, which always
    // carries the higher indices, so equal costs resolve to the highest slot.
    function automatic logic [CW-1:0] pick_min(input logic [CW-1:0] lo,
                                               input logic [CW-1:0] hi);
        if (lo[CW-1:4] < hi[CW-1:4]) begin
            pick_min = lo;
        end else begin
            pick_min = hi;
        end
    endfunction

    // Input qualification and the mask as it will look after this cycle.
    always_comb begin
        start_s  = iStart && ((state_r == ST_IDLE) || (state_r == ST_COLLECT));
        accept_s = (state_r == ST_COLLECT) && !iStart && iValid && (iIndex <= 4'd14);
        bad_s    = (state_r == ST_COLLECT) && !iStart && iValid && (iIndex > 4'd14);
        en_s     = (state_r == ST_FLUSH);
        if (accept_s) begin
            mask_s = mask_r | (MASK_ONE << iIndex);
        end else begin
            mask_s = mask_r;
        end
    end

    // State register.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (iStart) state_s = ST_COLLECT;
                else        state_s = ST_IDLE;
            end
            ST_COLLECT: begin
                if (iStart)                                 state_s = ST_COLLECT;
                else if (iFinish || (mask_s == MASK_FULL))  state_s = ST_FLUSH;
                else                                        state_s = ST_COLLECT;
            end
            ST_FLUSH: begin
                if (cnt_r == 2'd0) state_s = ST_CAPTURE;
                else               state_s = ST_FLUSH;
            end
            ST_CAPTURE: state_s = ST_DONE;
            ST_DONE:    state_s = ST_IDLE;
            default:    state_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the status flags are registered.
    always_comb begin
        ready_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        case (state_s)
            ST_COLLECT: ready_s = 1'b1;
            ST_FLUSH:   busy_s  = 1'b1;
            ST_CAPTURE: busy_s  = 1'b1;
            ST_DONE:    done_s  = 1'b1;
            default: begin
                ready_s = 1'b0;
                busy_s  = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    // Slot storage, received mask and sticky bad-index flag.
    always_ff @(posedge iClock) begin
        if (iReset || start_s) begin
            for (int i = 0; i < NCAND; i++) slot_r[i] <= {COST_W{1'b1}};
            mask_r <= {NCAND{1'b0}};
            err_r  <= 1'b0;
        end else begin
            for (int i = 0; i < NCAND; i++) begin
                if (accept_s && (iIndex == 4'(i))) slot_r[i] <= iCost;
            end
            mask_r <= mask_s;
            if (bad_s) err_r <= 1'b1;
        end
    end

    // FLUSH length counter: reloads outside FLUSH, counts down inside it.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            cnt_r <= 2'd0;
        end else if (state_r == ST_FLUSH) begin
            cnt_r <= cnt_r - 2'd1;
        end else begin
            cnt_r <= 2'(CMP_LAT - 1);
        end
    end

    // Tag each slot with its index for the minimum tree.
    always_comb begin
        for (int i = 0; i < NCAND; i++) cand_s[i] = {slot_r[i], 4'(i)};
    end

    // Four enabled reduction stages: 15 -> 8 -> 4 -> 2 -> 1.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            for (int i = 0; i < 8; i++) s1_r[i] <= {CW{1'b0}};
            for (int i = 0; i < 4; i++) s2_r[i] <= {CW{1'b0}};
            for (int i = 0; i < 2; i++) s3_r[i] <= {CW{1'b0}};
            s4_r <= {CW{1'b0}};
        end else if (en_s) begin
            for (int i = 0; i < 7; i++) s1_r[i] <= pick_min(cand_s[2*i], cand_s[2*i+1]);
            s1_r[7] <= cand_s[14];
            for (int i = 0; i < 4; i++) s2_r[i] <= pick_min(s1_r[2*i], s1_r[2*i+1]);
            for (int i = 0; i < 2; i++) s3_r[i] <= pick_min(s2_r[2*i], s2_r[2*i+1]);
            s4_r <= pick_min(s3_r[0], s3_r[1]);
        end
    end

    // Registered outputs; the result holds from CAPTURE until the next one.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            oReady     <= 1'b0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
            oBestIndex <= 4'd0;
            oBestCost  <= {COST_W{1'b0}};
            oEmpty     <= 1'b0;
        end else begin
            oReady <= ready_s;
            oBusy  <= busy_s;
            oDone  <= done_s;
            if (state_r == ST_CAPTURE) begin
                oBestIndex <= s4_r[3:0];
                oBestCost  <= s4_r[CW-1:4];
                oEmpty     <= (mask_r == {NCAND{1'b0}});
            end
        end
    end

    assign oError = err_r;

endmodule

// File: tb/tb_fir_order_scheduler.sv
// Directed bench for fir_order_scheduler: hand-computed expectations checked
// with immediate assertions along one linear stimulus sequence.
module tb_fir_order_scheduler;

    logic        iClock = 1'b0;
    logic        iReset;
    logic        iStart;
    logic        iValid;
    logic [3:0]  iIndex;
    logic [30:0] iCost;
    logic        oReady;
    logic        iFinish;
    logic        oBusy;
    logic        oDone;
    logic [3:0]  oBestIndex;
    logic [30:0] oBestCost;
    logic        oEmpty;
    logic        oError;

    int n_cmp = 0;
    int n_err = 0;
    int lat;
    int dones;

    fir_order_scheduler dut (
        .iClock(iClock), .iReset(iReset), .iStart(iStart), .iValid(iValid),
        .iIndex(iIndex), .iCost(iCost), .oReady(oReady), .iFinish(iFinish),
        .oBusy(oBusy), .oDone(oDone), .oBestIndex(oBestIndex),
        .oBestCost(oBestCost), .oEmpty(oEmpty), .oError(oError)
    );

    always #5 iClock = ~iClock;

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [3:0] idx, input logic [30:0] cost, input logic fin);
        iValid  = 1'b1;
        iIndex  = idx;
        iCost   = cost;
        iFinish = fin;
        step();
        iValid  = 1'b0;
        iFinish = 1'b0;
    endtask

    task automatic start_block();
        iStart = 1'b1;
        step();
        iStart = 1'b0;
    endtask

    // c0 = cycle number (1 = cycle right after the triggering edge) on entry.
    task automatic wait_done(input int c0, output int c);
        c = c0;
        while (oDone !== 1'b1 && c < 20) begin
            step();
            c++;
        end
    endtask

    initial begin
        iReset = 1'b1; iStart = 1'b0; iValid = 1'b0; iIndex = 4'd0;
        iCost = 31'd0; iFinish = 1'b0;
        step(); step(); step();
        chk("rst_ready", 64'(oReady), 64'd0);
        chk("rst_busy",  64'(oBusy),  64'd0);
        chk("rst_done",  64'(oDone),  64'd0);
        chk("rst_idx",   64'(oBestIndex), 64'd0);
        chk("rst_cost",  64'(oBestCost),  64'd0);
        chk("rst_empty", 64'(oEmpty), 64'd0);
        chk("rst_error", 64'(oError), 64'd0);
        iReset = 1'b0;
        step();
        chk("idle_ready", 64'(oReady), 64'd0);

        // Full block, auto-finish on the 15th distinct slot.
        start_block();
        chk("collect_ready", 64'(oReady), 64'd1);
        for (int i = 0; i < 15; i++) begin
            offer(4'(i), (i == 7) ? 31'd5 : 31'(1000 - 10 * i), 1'b0);
            if (i == 13) chk("full_ready_14", 64'(oReady), 64'd1);
        end
        chk("full_flush_ready", 64'(oReady), 64'd0);
        chk("full_flush_busy",  64'(oBusy),  64'd1);
        wait_done(1, lat);
        chk("full_latency", 64'(lat), 64'd6);
        chk("full_busy_done", 64'(oBusy), 64'd0);
        chk("full_idx",   64'(oBestIndex), 64'd7);
        chk("full_cost",  64'(oBestCost),  64'd5);
        chk("full_empty", 64'(oEmpty), 64'd0);
        chk("full_error", 64'(oError), 64'd0);
        step();
        chk("full_pulse", 64'(oDone), 64'd0);
        chk("full_hold",  64'(oBestIndex), 64'd7);

        // Partial block, iFinish with the last accept; FLUSH ignores offers.
        start_block();
        offer(4'd2, 31'd40, 1'b0);
        offer(4'd9, 31'd30, 1'b0);
        offer(4'd12, 31'd31, 1'b1);
        chk("part_ready", 64'(oReady), 64'd0);
        offer(4'd0, 31'd0, 1'b0);
        wait_done(2, lat);
        chk("part_latency", 64'(lat), 64'd6);
        chk("part_idx",  64'(oBestIndex), 64'd9);
        chk("part_cost", 64'(oBestCost),  64'd30);
        step();

        // Duplicate overwrite and tie toward the highest index.
        start_block();
        offer(4'd3, 31'd100, 1'b0);
        offer(4'd3, 31'd50, 1'b0);
        offer(4'd5, 31'd50, 1'b0);
        offer(4'd11, 31'd50, 1'b1);
        wait_done(1, lat);
        chk("tie_latency", 64'(lat), 64'd6);
        chk("tie_idx",  64'(oBestIndex), 64'd11);
        chk("tie_cost", 64'(oBestCost),  64'd50);
        step();

        // Empty block with a bad index.
        start_block();
        offer(4'd15, 31'd0, 1'b0);
        chk("err_set", 64'(oError), 64'd1);
        iFinish = 1'b1;
        step();
        iFinish = 1'b0;
        wait_done(1, lat);
        chk("empty_latency", 64'(lat), 64'd6);
        chk("empty_flag",  64'(oEmpty), 64'd1);
        chk("empty_idx",   64'(oBestIndex), 64'd14);
        chk("empty_cost",  64'(oBestCost),  64'h7FFF_FFFF);
        chk("err_sticky",  64'(oError), 64'd1);
        step();
        start_block();
        chk("err_cleared", 64'(oError), 64'd0);

        // Reset during the second FLUSH cycle aborts the block.
        offer(4'd3, 31'd7, 1'b1);
        step();
        iReset = 1'b1;
        step();
        chk("mid_rst_busy",  64'(oBusy), 64'd0);
        chk("mid_rst_done",  64'(oDone), 64'd0);
        chk("mid_rst_idx",   64'(oBestIndex), 64'd0);
        chk("mid_rst_cost",  64'(oBestCost),  64'd0);
        chk("mid_rst_empty", 64'(oEmpty), 64'd0);
        iReset = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (oDone === 1'b1) dones++;
        end
        chk("abort_no_done", 64'(dones), 64'd0);
        start_block();
        offer(4'd0, 31'd1, 1'b1);
        wait_done(1, lat);
        chk("post_rst_latency", 64'(lat), 64'd6);
        chk("post_rst_idx",  64'(oBestIndex), 64'd0);
        chk("post_rst_cost", 64'(oBestCost),  64'd1);
        step();

        // Restart inside COLLECT discards earlier candidates.
        start_block();
        offer(4'd4, 31'd1, 1'b0);
        start_block();
        offer(4'd6, 31'd9, 1'b1);
        wait_done(1, lat);
        chk("restart_latency", 64'(lat), 64'd6);
        chk("restart_idx",  64'(oBestIndex), 64'd6);
        chk("restart_cost", 64'(oBestCost),  64'd9);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
